// File: rtl/bram_dp.sv
// ----------------------------------------------------------------------------
// bram_dp: true dual-port, byte-writable word memory with a zero-fill engine.
//
// Both ports are byte-addressed; the word index is the address with its two
// low bits dropped. Every enabled access returns a read of the (post-write)
// word RD_LAT cycles later. When both ports touch the same word in the same
// cycle, port A wins on overlapping byte lanes, and each port sees the word
// as it looks after both writes.
//
// After reset release, or on CLR, an IDLE/FILL state machine zeroes one word
// per cycle. While that fill runs, port writes are dropped and reads return
// zero.
//
// Ports:
//   CLK, RST_N        clock (rising edge), asynchronous active-low reset
//   CLR               pulse: start (or restart) the zero-fill
//   BUSY              zero-fill in progress
//   ENA/ENB           port access enable
//   WEA/WEB           port byte write enables
//   AA/AB             port byte address
//   DiA/DiB           port write data
//   DoA/DoB           port read data (holds while Dv is low)
//   DvA/DvB           port read data valid
//   ERR               one-cycle pulse after an out-of-range access
// ----------------------------------------------------------------------------
module bram_dp #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 16,
   parameter int ADDR_W = 12,
   parameter int RD_LAT = 1
) (
   input  logic                CLK,
   input  logic                RST_N,
   input  logic                CLR,
   output logic                BUSY,
   input  logic                ENA,
   input  logic [DATA_W/8-1:0] WEA,
   input  logic [ADDR_W-1:0]   AA,
   input  logic [DATA_W-1:0]   DiA,
   output logic [DATA_W-1:0]   DoA,
   output logic                DvA,
   input  logic                ENB,
   input  logic [DATA_W/8-1:0] WEB,
   input  logic [ADDR_W-1:0]   AB,
   input  logic [DATA_W-1:0]   DiB,
   output logic [DATA_W-1:0]   DoB,
   output logic                DvB,
   output logic                ERR
);

   localparam int NB = DATA_W / 8;
   localparam int WI = ADDR_W - 2;
   localparam int CW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(DEPTH - 1);

   typedef enum logic {IDLE, FILL} state_t;

   state_t            state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              need_fill_q, need_fill_d;
   logic              err_q, err_d;
   logic              va1_q, va1_d, va2_q, va2_d;
   logic              vb1_q, vb1_d, vb2_q, vb2_d;
   logic [DATA_W-1:0] da1_q, da1_d, da2_q, da2_d;
   logic [DATA_W-1:0] db1_q, db1_d, db2_q, db2_d;

   logic [DATA_W-1:0] mem_q [DEPTH];

   logic              busy;
   logic [WI-1:0]     idx_a, idx_b;
   logic [CW-1:0]     wa, wb;
   logic              in_a, in_b, acc_a, acc_b, same_word;
   logic [NB-1:0]     wr_a, wr_b;
   logic [DATA_W-1:0] rd_a, rd_b;
   logic              unused_low;

   assign busy       = (state_q == FILL);
   assign unused_low = ^{AA[1:0], AB[1:0]};

   // Fill state machine. need_fill_q is set by reset so the first clock
   // after release starts a fill; a CLR during FILL rewinds the counter.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      need_fill_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (need_fill_q || CLR) begin
               state_d = FILL;
               cnt_d   = '0;
            end
         end
         FILL: begin
            if (CLR) begin
               cnt_d = '0;
            end else if (cnt_q == LAST) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Port decode and write-first read data. Out-of-range or busy accesses
   // write nothing and read zero; port A owns overlapping byte lanes.
   always_comb begin
      idx_a     = AA[ADDR_W-1:2];
      idx_b     = AB[ADDR_W-1:2];
      in_a      = ({{(32-WI){1'b0}}, idx_a} < 32'(DEPTH));
      in_b      = ({{(32-WI){1'b0}}, idx_b} < 32'(DEPTH));
      wa        = idx_a[CW-1:0];
      wb        = idx_b[CW-1:0];
      acc_a     = ENA && !busy;
      acc_b     = ENB && !busy;
      wr_a      = (acc_a && in_a) ? WEA : '0;
      wr_b      = (acc_b && in_b) ? WEB : '0;
      same_word = in_a && in_b && (wa == wb);
      rd_a      = '0;
      rd_b      = '0;
      if (acc_a && in_a) begin
         rd_a = mem_q[wa];
         for (int i = 0; i < NB; i++) begin
            if (wr_a[i])
               rd_a[i*8 +: 8] = DiA[i*8 +: 8];
            else if (same_word && wr_b[i])
               rd_a[i*8 +: 8] = DiB[i*8 +: 8];
         end
      end
      if (acc_b && in_b) begin
         rd_b = mem_q[wb];
         for (int i = 0; i < NB; i++) begin
            if (same_word && wr_a[i])
               rd_b[i*8 +: 8] = DiA[i*8 +: 8];
            else if (wr_b[i])
               rd_b[i*8 +: 8] = DiB[i*8 +: 8];
         end
      end
      err_d = (acc_a && !in_a) || (acc_b && !in_b);
   end

   // Read pipelines: data registers only load on a valid beat, so the
   // outputs hold their last value while valid is low.
   always_comb begin
      va1_d = ENA;
      vb1_d = ENB;
      da1_d = ENA ? rd_a : da1_q;
      db1_d = ENB ? rd_b : db1_q;
      va2_d = va1_q;
      vb2_d = vb1_q;
      da2_d = va1_q ? da1_q : da2_q;
      db2_d = vb1_q ? db1_q : db2_q;
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         need_fill_q <= 1'b1;
         err_q       <= 1'b0;
         va1_q       <= 1'b0;
         va2_q       <= 1'b0;
         vb1_q       <= 1'b0;
         vb2_q       <= 1'b0;
         da1_q       <= '0;
         da2_q       <= '0;
         db1_q       <= '0;
         db2_q       <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         need_fill_q <= need_fill_d;
         err_q       <= err_d;
         va1_q       <= va1_d;
         va2_q       <= va2_d;
         vb1_q       <= vb1_d;
         vb2_q       <= vb2_d;
         da1_q       <= da1_d;
         da2_q       <= da2_d;
         db1_q       <= db1_d;
         db2_q       <= db2_d;
      end
   end

   // Storage. Port B lanes are written before port A lanes so that A's
   // later assignment takes the overlapping bytes.
   always_ff @(posedge CLK) begin
      if (busy) begin
         mem_q[cnt_q] <= '0;
      end else begin
         for (int i = 0; i < NB; i++) begin
            if (wr_b[i])
               mem_q[wb][i*8 +: 8] <= DiB[i*8 +: 8];
         end
         for (int i = 0; i < NB; i++) begin
            if (wr_a[i])
               mem_q[wa][i*8 +: 8] <= DiA[i*8 +: 8];
         end
      end
   end

   assign BUSY = busy;
   assign ERR  = err_q;
   assign DoA  = (RD_LAT == 2) ? da2_q : da1_q;
   assign DvA  = (RD_LAT == 2) ? va2_q : va1_q;
   assign DoB  = (RD_LAT == 2) ? db2_q : db1_q;
   assign DvB  = (RD_LAT == 2) ? vb2_q : vb1_q;

endmodule

// File: tb/tb_bram_dp.sv
// ----------------------------------------------------------------------------
// tb_bram_dp: directed bench for bram_dp. Two instances share all inputs:
// u_lat1 with one-cycle read latency and u_lat2 with two-cycle latency.
// ----------------------------------------------------------------------------
module tb_bram_dp;

   logic        clk = 1'b0;
   logic        rst_n, clr, ena, enb;
   logic [3:0]  wea, web;
   logic [11:0] aa, ab;
   logic [31:0] dia, dib;

   logic        busy1, dva1, dvb1, err1;
   logic [31:0] doa1, dob1;
   logic        busy2, dva2, dvb2, err2;
   logic [31:0] doa2, dob2;

   int vec_cnt  = 0;
   int miss_cnt = 0;

   always #5 clk = ~clk;

   bram_dp #(.DATA_W(32), .DEPTH(16), .ADDR_W(12), .RD_LAT(1)) u_lat1 (
      .CLK(clk), .RST_N(rst_n), .CLR(clr), .BUSY(busy1),
      .ENA(ena), .WEA(wea), .AA(aa), .DiA(dia), .DoA(doa1), .DvA(dva1),
      .ENB(enb), .WEB(web), .AB(ab), .DiB(dib), .DoB(dob1), .DvB(dvb1),
      .ERR(err1)
   );

   bram_dp #(.DATA_W(32), .DEPTH(16), .ADDR_W(12), .RD_LAT(2)) u_lat2 (
      .CLK(clk), .RST_N(rst_n), .CLR(clr), .BUSY(busy2),
      .ENA(ena), .WEA(wea), .AA(aa), .DiA(dia), .DoA(doa2), .DvA(dva2),
      .ENB(enb), .WEB(web), .AB(ab), .DiB(dib), .DoB(dob2), .DvB(dvb2),
      .ERR(err2)
   );

   // Advance one clock and settle just past the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      clr = 1'b0; ena = 1'b0; enb = 1'b0; wea = '0; web = '0;
   endtask

   task automatic drive_a(input logic [11:0] addr, input logic [3:0] we, input logic [31:0] d);
      ena = 1'b1; aa = addr; wea = we; dia = d;
   endtask

   task automatic drive_b(input logic [11:0] addr, input logic [3:0] we, input logic [31:0] d);
      enb = 1'b1; ab = addr; web = we; dib = d;
   endtask

   task automatic test_reset();
      rst_n = 1'b1; idle_inputs(); aa = '0; ab = '0; dia = '0; dib = '0;
      #2 rst_n = 1'b0;
      tick(); tick();
      vec_cnt++; if (busy1 !== 1'b0) begin miss_cnt++; $display("[TB] FAIL reset_busy: got %b expected 0", busy1); end
      vec_cnt++; if (dva1 !== 1'b0) begin miss_cnt++; $display("[TB] FAIL reset_dva: got %b expected 0", dva1); end
      vec_cnt++; if (dvb1 !== 1'b0) begin miss_cnt++; $display("[TB] FAIL reset_dvb: got %b expected 0", dvb1); end
      vec_cnt++; if (doa1 !== 32'h0) begin miss_cnt++; $display("[TB] FAIL reset_doa: got %h expected 0", doa1); end
      vec_cnt++; if (err1 !== 1'b0) begin miss_cnt++; $display("[TB] FAIL reset_err: got %b expected 0", err1); end
      vec_cnt++; if (dva2 !== 1'b0) begin miss_cnt++; $display("[TB] FAIL reset_dva_lat2: got %b expected 0", dva2); end
   endtask

   task automatic test_fill();
      int  busy_cycles = 0;
      bit  seen = 1'b0;
      rst_n = 1'b1;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (busy1) begin busy_cycles++; seen = 1'b1; end
         else if (seen) break;
      end
      vec_cnt++; if (busy_cycles !== 16) begin miss_cnt++; $display("[TB] FAIL fill_busy_cycles: got %0d expected 16", busy_cycles); end
      for (int w = 0; w < 16; w++) begin
         drive_a(12'(w * 4), 4'h0, 32'h0);
         tick();
         idle_inputs();
         vec_cnt++;
         if (dva1 !== 1'b1 || doa1 !== 32'h0) begin
            miss_cnt++; $display("[TB] FAIL fill_read_w%0d: got dv=%b do=%h expected dv=1 do=00000000", w, dva1, doa1);
         end
      end
   endtask

   task automatic test_byte_write();
      drive_a(12'h008, 4'b1111, 32'hDEADBEEF); tick();
      drive_a(12'h008, 4'b0001, 32'h000000AA); tick(); idle_inputs();
      vec_cnt++; if (doa1 !== 32'hDEADBEAA) begin miss_cnt++; $display("[TB] FAIL write_first_a: got %h expected DEADBEAA", doa1); end
      drive_b(12'h008, 4'b0000, 32'h0); tick(); idle_inputs();
      vec_cnt++; if (dvb1 !== 1'b1) begin miss_cnt++; $display("[TB] FAIL byte_read_dvb: got %b expected 1", dvb1); end
      vec_cnt++; if (dob1 !== 32'hDEADBEAA) begin miss_cnt++; $display("[TB] FAIL byte_read_dob: got %h expected DEADBEAA", dob1); end
      tick();
      vec_cnt++; if (dvb1 !== 1'b0) begin miss_cnt++; $display("[TB] FAIL idle_dvb: got %b expected 0", dvb1); end
      vec_cnt++; if (dob1 !== 32'hDEADBEAA) begin miss_cnt++; $display("[TB] FAIL hold_dob: got %h expected DEADBEAA", dob1); end
   endtask

   task automatic test_collision();
      drive_a(12'h00C, 4'b0011, 32'h11111111);
      drive_b(12'h00C, 4'b0110, 32'h22222222);
      tick(); idle_inputs();
      vec_cnt++; if (doa1 !== 32'h00221111) begin miss_cnt++; $display("[TB] FAIL collide_doa: got %h expected 00221111", doa1); end
      vec_cnt++; if (dob1 !== 32'h00221111) begin miss_cnt++; $display("[TB] FAIL collide_dob: got %h expected 00221111", dob1); end
      drive_a(12'h00C, 4'b0000, 32'h0); tick(); idle_inputs();
      vec_cnt++; if (doa1 !== 32'h00221111) begin miss_cnt++; $display("[TB] FAIL collide_readback: got %h expected 00221111", doa1); end
      // Port A reads word 5 while port B writes it.
      drive_a(12'h014, 4'b0000, 32'h0);
      drive_b(12'h014, 4'b1111, 32'h12345678);
      tick(); idle_inputs();
      vec_cnt++; if (doa1 !== 32'h12345678) begin miss_cnt++; $display("[TB] FAIL cross_read: got %h expected 12345678", doa1); end
   endtask

   task automatic test_out_of_range();
      drive_a(12'h040, 4'b0000, 32'h0); tick(); idle_inputs();
      vec_cnt++; if (dva1 !== 1'b1 || doa1 !== 32'h0) begin miss_cnt++; $display("[TB] FAIL oor_read: got dv=%b do=%h expected dv=1 do=00000000", dva1, doa1); end
      vec_cnt++; if (err1 !== 1'b1) begin miss_cnt++; $display("[TB] FAIL oor_err: got %b expected 1", err1); end
      tick();
      vec_cnt++; if (err1 !== 1'b0) begin miss_cnt++; $display("[TB] FAIL oor_err_pulse: got %b expected 0", err1); end
      drive_a(12'h044, 4'b1111, 32'hFFFFFFFF); tick(); idle_inputs();
      vec_cnt++; if (err1 !== 1'b1 || doa1 !== 32'h0) begin miss_cnt++; $display("[TB] FAIL oor_write: got err=%b do=%h expected err=1 do=00000000", err1, doa1); end
      drive_a(12'h004, 4'b0000, 32'h0); tick(); idle_inputs();
      vec_cnt++; if (doa1 !== 32'h0) begin miss_cnt++; $display("[TB] FAIL oor_no_alias_w1: got %h expected 00000000", doa1); end
      drive_a(12'h008, 4'b0000, 32'h0); tick(); idle_inputs();
      vec_cnt++; if (doa1 !== 32'hDEADBEAA) begin miss_cnt++; $display("[TB] FAIL oor_unchanged_w2: got %h expected DEADBEAA", doa1); end
   endtask

   task automatic test_clr_restart();
      int busy_cycles;
      clr = 1'b1; tick(); clr = 1'b0;
      vec_cnt++; if (busy1 !== 1'b1) begin miss_cnt++; $display("[TB] FAIL clr_busy: got %b expected 1", busy1); end
      repeat (5) tick();
      clr = 1'b1; tick(); clr = 1'b0;
      busy_cycles = busy1 ? 1 : 0;
      for (int i = 0; i < 40; i++) begin
         if (i == 3) begin
            drive_a(12'h000, 4'b1111, 32'hFFFFFFFF);
            drive_b(12'h080, 4'b1111, 32'hFFFFFFFF);
         end
         tick();
         if (i == 3) begin
            idle_inputs();
            vec_cnt++; if (dva1 !== 1'b1 || doa1 !== 32'h0) begin miss_cnt++; $display("[TB] FAIL busy_read_a: got dv=%b do=%h expected dv=1 do=00000000", dva1, doa1); end
            vec_cnt++; if (dvb1 !== 1'b1 || dob1 !== 32'h0) begin miss_cnt++; $display("[TB] FAIL busy_read_b: got dv=%b do=%h expected dv=1 do=00000000", dvb1, dob1); end
            vec_cnt++; if (err1 !== 1'b0) begin miss_cnt++; $display("[TB] FAIL busy_err: got %b expected 0", err1); end
         end
         if (busy1) busy_cycles++;
         else break;
      end
      vec_cnt++; if (busy_cycles !== 16) begin miss_cnt++; $display("[TB] FAIL clr_busy_cycles: got %0d expected 16", busy_cycles); end
      for (int w = 0; w < 16; w++) begin
         drive_a(12'(w * 4), 4'h0, 32'h0);
         tick();
         idle_inputs();
         vec_cnt++;
         if (dva1 !== 1'b1 || doa1 !== 32'h0) begin
            miss_cnt++; $display("[TB] FAIL clr_read_w%0d: got dv=%b do=%h expected dv=1 do=00000000", w, dva1, doa1);
         end
      end
   endtask

   task automatic test_back_to_back();
      drive_a(12'h000, 4'b1111, 32'hA0A0A0A0); tick();
      drive_a(12'h004, 4'b1111, 32'hB1B1B1B1); tick();
      drive_a(12'h008, 4'b1111, 32'hC2C2C2C2); tick();
      idle_inputs(); tick(); tick(); tick();
      drive_a(12'h000, 4'b0000, 32'h0); tick();
      vec_cnt++; if (dva2 !== 1'b0) begin miss_cnt++; $display("[TB] FAIL lat2_early: got %b expected 0", dva2); end
      vec_cnt++; if (doa1 !== 32'hA0A0A0A0) begin miss_cnt++; $display("[TB] FAIL lat1_w0: got %h expected A0A0A0A0", doa1); end
      drive_a(12'h004, 4'b0000, 32'h0); tick();
      vec_cnt++; if (dva2 !== 1'b1 || doa2 !== 32'hA0A0A0A0) begin miss_cnt++; $display("[TB] FAIL lat2_w0: got dv=%b do=%h expected dv=1 do=A0A0A0A0", dva2, doa2); end
      drive_a(12'h008, 4'b0000, 32'h0); tick(); idle_inputs();
      vec_cnt++; if (dva2 !== 1'b1 || doa2 !== 32'hB1B1B1B1) begin miss_cnt++; $display("[TB] FAIL lat2_w1: got dv=%b do=%h expected dv=1 do=B1B1B1B1", dva2, doa2); end
      tick();
      vec_cnt++; if (dva2 !== 1'b1 || doa2 !== 32'hC2C2C2C2) begin miss_cnt++; $display("[TB] FAIL lat2_w2: got dv=%b do=%h expected dv=1 do=C2C2C2C2", dva2, doa2); end
      tick();
      vec_cnt++; if (dva2 !== 1'b0 || doa2 !== 32'hC2C2C2C2) begin miss_cnt++; $display("[TB] FAIL lat2_hold: got dv=%b do=%h expected dv=0 do=C2C2C2C2", dva2, doa2); end
   endtask

   task automatic test_reset_midfill();
      int  busy_cycles = 0;
      bit  seen = 1'b0;
      clr = 1'b1; tick(); clr = 1'b0;
      repeat (4) tick();
      rst_n = 1'b0;
      #1;
      vec_cnt++; if (busy1 !== 1'b0) begin miss_cnt++; $display("[TB] FAIL midfill_busy: got %b expected 0", busy1); end
      vec_cnt++; if (doa1 !== 32'h0 || dva1 !== 1'b0) begin miss_cnt++; $display("[TB] FAIL midfill_doa: got dv=%b do=%h expected dv=0 do=00000000", dva1, doa1); end
      vec_cnt++; if (doa2 !== 32'h0) begin miss_cnt++; $display("[TB] FAIL midfill_doa_lat2: got %h expected 00000000", doa2); end
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (busy1) begin busy_cycles++; seen = 1'b1; end
         else if (seen) break;
      end
      vec_cnt++; if (busy_cycles !== 16) begin miss_cnt++; $display("[TB] FAIL midfill_busy_cycles: got %0d expected 16", busy_cycles); end
   endtask

   initial begin
      test_reset();
      test_fill();
      test_byte_write();
      test_collision();
      test_out_of_range();
      test_clr_restart();
      test_back_to_back();
      test_reset_midfill();
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
      $finish;
   end

endmodule

// File: doc/bram_dp.md
BRAM_DP -- requirements
Module: bram_dp

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  DATA_W  32  word width in bits; multiple of 8
  DEPTH   16  words stored
  ADDR_W  12  byte-address width; word index = address >> 2
  RD_LAT  1   read latency in cycles; legal values 1 or 2
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
  CLK     in   1             single clock, rising edge
  RST_N   in   1             reset, asynchronous, active-low
  CLR     in   1             pulse: start zero-fill of all words
  BUSY    out  1             zero-fill in progress
  ENA     in   1             port A access enable
  WEA     in   DATA_W/8      port A byte write enables
  AA      in   ADDR_W        port A byte address
  DiA     in   DATA_W        port A write data
  DoA     out  DATA_W        port A read data
  DvA     out  1             port A read data valid
  ENB, WEB, AB, DiB, DoB, DvB  same as port A, for port B
  ERR     out  1             one-cycle pulse: out-of-range access

Function
REQ-003 Each port SHALL accept one access per cycle when EN=1 and BUSY=0; WE bit i writes byte i of the addressed word at the clock edge.
REQ-004 A read (EN=1, WE=0) SHALL present data on Do with Dv=1 exactly RD_LAT cycles later; Do SHALL hold its last value while Dv=0.
REQ-005 An access with EN=1 and any WE bit set SHALL also produce a read of the post-write word (write-first), with the same latency as REQ-004.
REQ-006 When both ports write the same word in the same cycle, each byte enabled on both ports SHALL take port A data; the remaining enabled bytes SHALL take their own port's data.
REQ-007 A read on one port of a word written by the other port in the same cycle SHALL return the post-write value.
REQ-008 An access with word index >= DEPTH SHALL write nothing, SHALL return all-zero data with Dv=1 at normal latency, and SHALL pulse ERR one cycle after the access.
REQ-009 The zero-fill FSM SHALL have states IDLE and FILL: IDLE->FILL on reset release or on CLR=1; in FILL, one word SHALL be zeroed per cycle, indices 0 to DEPTH-1; FILL->IDLE after index DEPTH-1 is written.
REQ-010 BUSY SHALL equal 1 exactly while the FSM is in FILL, lasting DEPTH cycles.
REQ-011 While BUSY=1, port writes SHALL be dropped, and port reads SHALL return zero with Dv=1 at normal latency; ERR SHALL NOT pulse.
REQ-012 CLR asserted while in FILL SHALL restart the fill at index 0.
REQ-013 The fill counter SHALL be clog2(DEPTH) bits wide and SHALL NOT wrap past DEPTH-1.
REQ-014 With RD_LAT=2, reads issued in back-to-back cycles SHALL emerge in back-to-back cycles in issue order, with no bubbles.

Reset
REQ-015 RST_N=0 SHALL asynchronously force: BUSY=0, DvA=DvB=0, DoA=DoB=0, ERR=0, FSM=IDLE, fill counter=0, read pipelines cleared.
REQ-016 On the first clock edge with RST_N=1, the FSM SHALL enter FILL; memory contents are undefined until that fill completes.
REQ-017 Reset asserted mid-fill SHALL abort the fill; on release the fill SHALL restart at index 0.

Verification
REQ-018 Scenario: release reset; count BUSY cycles -> exactly DEPTH (16); afterwards, a read of every word returns 0.
REQ-019 Scenario: port A writes 0xDEADBEEF to AA=0x8 with WEA=4'b1111, then writes 0x000000AA with WEA=4'b0001; read on port B -> DoB=0xDEADBEAA with DvB=1, RD_LAT cycles after the read.
REQ-020 Scenario: in the same cycle, A writes 0x11111111 with WEA=4'b0011 and B writes 0x22222222 with WEB=4'b0110, both to word 3 -> word 3 reads 0x00221111.
REQ-021 Scenario: read AA=0x40 (word 16) with DEPTH=16 -> DoA=0, DvA=1, one ERR pulse; memory unchanged.
REQ-022 Scenario: pulse CLR at fill index 5, then write during BUSY -> fill restarts (BUSY lasts 16 more cycles), the write is dropped, and all words read 0.
REQ-023 Scenario: RD_LAT=2, reads of words 0,1,2 on consecutive cycles -> DvA high for three consecutive cycles starting 2 cycles later, data in order.
